// File: rtl/accum_alu_pkg.sv
// -----------------------------------------------------------------------------
// accum_alu_pkg
// Shared types and constants for the accumulator ALU slice.
//   op_e  : 4-bit command opcodes; values 0..3 keep the legacy 2-bit encodings.
//   fsm_e : controller states (IDLE accepts commands, MUL runs the multiplier).
// -----------------------------------------------------------------------------
package accum_alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_OR   = 4'd2,
    OP_XOR  = 4'd3,
    OP_AND  = 4'd4,
    OP_SHL  = 4'd5,
    OP_SHR  = 4'd6,
    OP_MUL  = 4'd7,
    OP_LOAD = 4'd8,
    OP_CLR  = 4'd9
  } op_e;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } fsm_e;

  // Opcodes from here upward are accepted but leave result and flags alone.
  localparam logic [3:0] OP_RESERVED_MIN = 4'd10;

  function automatic logic is_reserved(input logic [3:0] code);
    return (code >= OP_RESERVED_MIN);
  endfunction

endpackage

// File: rtl/accum_alu_seq_mul.sv
// -----------------------------------------------------------------------------
// seq_mul
// Unsigned shift-add multiplier, one partial product per clock.
//   clock, reset_L : clock and asynchronous active-low reset
//   start          : load a and b and begin (ignored result of any run in flight)
//   a, b           : WIDTH-bit unsigned multiplicand / multiplier
//   busy           : iterations in progress
//   done           : high during the cycle whose rising edge completes the
//                    last iteration; product is valid in that same cycle
//   product        : 2*WIDTH-bit product (combinational view of the final sum)
// The WIDTH iterations occupy the WIDTH edges following the start edge, so a
// caller sampling product while done is high registers the full product at
// start_edge + WIDTH.
// -----------------------------------------------------------------------------
module seq_mul #(
  parameter int WIDTH = 8
) (
  input  logic                 clock,
  input  logic                 reset_L,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [2*WIDTH-1:0] acc_r;
  logic [2*WIDTH-1:0] mcand_r;
  logic [WIDTH-1:0]   mplier_r;
  logic [CNT_W-1:0]   count_r;
  logic               busy_r;
  logic [2*WIDTH-1:0] addend_s;
  logic [2*WIDTH-1:0] sum_s;

  assign addend_s = mplier_r[0] ? mcand_r : {(2*WIDTH){1'b0}};
  assign sum_s    = acc_r + addend_s;

  assign busy    = busy_r;
  assign done    = busy_r && (count_r == LAST);
  // On the final iteration the next accumulator value is the complete product.
  assign product = sum_s;

  // Operand capture and one shift-add step per cycle while busy.
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      acc_r    <= {(2*WIDTH){1'b0}};
      mcand_r  <= {(2*WIDTH){1'b0}};
      mplier_r <= {WIDTH{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      busy_r   <= 1'b0;
    end else if (start) begin
      acc_r    <= {(2*WIDTH){1'b0}};
      mcand_r  <= {{WIDTH{1'b0}}, a};
      mplier_r <= b;
      count_r  <= {CNT_W{1'b0}};
      busy_r   <= 1'b1;
    end else if (busy_r) begin
      acc_r    <= sum_s;
      mcand_r  <= {mcand_r[2*WIDTH-2:0], 1'b0};
      mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
      if (count_r == LAST) begin
        count_r <= {CNT_W{1'b0}};
        busy_r  <= 1'b0;
      end else begin
        count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        busy_r  <= 1'b1;
      end
    end else begin
      acc_r    <= acc_r;
      mcand_r  <= mcand_r;
      mplier_r <= mplier_r;
      count_r  <= count_r;
      busy_r   <= busy_r;
    end
  end

endmodule

// File: rtl/accum_alu_seq.sv
// -----------------------------------------------------------------------------
// accum_alu_seq
// WIDTH-bit accumulator updated by (op, operand) commands over valid/ready.
//   clock, reset_L   : clock and asynchronous active-low reset
//   in_valid/in_ready: command handshake; in_ready is high only in IDLE
//   op, operand      : 4-bit opcode (see accum_alu_pkg::op_e) and unsigned operand
//   sat_en           : clamp ADD/SUB/MUL instead of wrapping (sampled with command)
//   result           : registered accumulator
//   flag_zero/carry/ovf : status of the last committed non-reserved op
//   done             : one-cycle pulse after every commit (reserved ops included)
// Single-cycle ops commit at the accepting edge; MUL hands off to seq_mul and
// commits WIDTH edges later.
// -----------------------------------------------------------------------------
module accum_alu_seq
  import accum_alu_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = $clog2(WIDTH) + 1
) (
  input  logic             clock,
  input  logic             reset_L,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] operand,
  input  logic             sat_en,
  output logic [WIDTH-1:0] result,
  output logic             flag_zero,
  output logic             flag_carry,
  output logic             flag_ovf,
  output logic             done
);

  localparam logic [WIDTH-1:0]   ALL_ONES  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0]   ALL_ZERO  = {WIDTH{1'b0}};
  localparam logic [SHAMT_W-1:0] SHAMT_LIM = SHAMT_W'(WIDTH);

  fsm_e               state_r, state_nxt;
  logic [WIDTH-1:0]   result_r, result_nxt;
  logic               zero_r, zero_nxt;
  logic               carry_r, carry_nxt;
  logic               ovf_r, ovf_nxt;
  logic               done_r, done_nxt;
  logic               mul_sat_r, mul_sat_nxt;

  logic [WIDTH:0]     sum_s;
  logic [WIDTH:0]     diff_s;
  logic [SHAMT_W-1:0] shamt_s;
  logic [2*WIDTH-1:0] shl_ext_s;
  logic [2*WIDTH-1:0] shr_ext_s;
  logic [WIDTH-1:0]   alu_res_s;
  logic               alu_carry_s;
  logic               alu_ovf_s;

  logic               mul_start_s;
  logic               mul_busy_s;
  logic               mul_done_s;
  logic [2*WIDTH-1:0] mul_product_s;
  logic               mul_hi_nz_s;
  logic [WIDTH-1:0]   mul_res_s;

  assign sum_s   = {1'b0, result_r} + {1'b0, operand};
  assign diff_s  = {1'b0, result_r} - {1'b0, operand};
  assign shamt_s = operand[SHAMT_W-1:0];
  // Widened shifts: the half that leaves the accumulator shows what fell off.
  assign shl_ext_s = {ALL_ZERO, result_r} << shamt_s;
  assign shr_ext_s = {result_r, ALL_ZERO} >> shamt_s;

  seq_mul #(.WIDTH(WIDTH)) u_mul (
    .clock   (clock),
    .reset_L (reset_L),
    .start   (mul_start_s),
    .a       (result_r),
    .b       (operand),
    .busy    (mul_busy_s),
    .done    (mul_done_s),
    .product (mul_product_s)
  );

  assign mul_hi_nz_s = |mul_product_s[2*WIDTH-1:WIDTH];
  assign mul_res_s   = (mul_sat_r && mul_hi_nz_s) ? ALL_ONES : mul_product_s[WIDTH-1:0];

  // Result and flags for every single-cycle opcode.
  always_comb begin
    alu_res_s   = result_r;
    alu_carry_s = 1'b0;
    alu_ovf_s   = 1'b0;
    case (op)
      OP_ADD: begin
        alu_carry_s = sum_s[WIDTH];
        alu_ovf_s   = (result_r[WIDTH-1] == operand[WIDTH-1]) &&
                      (sum_s[WIDTH-1] != result_r[WIDTH-1]);
        alu_res_s   = (sat_en && sum_s[WIDTH]) ? ALL_ONES : sum_s[WIDTH-1:0];
      end
      OP_SUB: begin
        // The extra top bit of the difference is the unsigned borrow.
        alu_carry_s = diff_s[WIDTH];
        alu_ovf_s   = (result_r[WIDTH-1] != operand[WIDTH-1]) &&
                      (diff_s[WIDTH-1] != result_r[WIDTH-1]);
        alu_res_s   = (sat_en && diff_s[WIDTH]) ? ALL_ZERO : diff_s[WIDTH-1:0];
      end
      OP_OR:   alu_res_s = result_r | operand;
      OP_XOR:  alu_res_s = result_r ^ operand;
      OP_AND:  alu_res_s = result_r & operand;
      OP_SHL: begin
        if (shamt_s >= SHAMT_LIM) begin
          alu_res_s   = ALL_ZERO;
          alu_carry_s = |result_r;
        end else begin
          alu_res_s   = shl_ext_s[WIDTH-1:0];
          alu_carry_s = |shl_ext_s[2*WIDTH-1:WIDTH];
        end
      end
      OP_SHR: begin
        if (shamt_s >= SHAMT_LIM) begin
          alu_res_s   = ALL_ZERO;
          alu_carry_s = |result_r;
        end else begin
          alu_res_s   = shr_ext_s[2*WIDTH-1:WIDTH];
          alu_carry_s = |shr_ext_s[WIDTH-1:0];
        end
      end
      OP_LOAD: alu_res_s = operand;
      OP_CLR:  alu_res_s = ALL_ZERO;
      default: alu_res_s = result_r;
    endcase
  end

  assign in_ready = (state_r == IDLE);

  // Controller: command acceptance, MUL hand-off and commit selection.
  always_comb begin
    state_nxt   = state_r;
    result_nxt  = result_r;
    zero_nxt    = zero_r;
    carry_nxt   = carry_r;
    ovf_nxt     = ovf_r;
    done_nxt    = 1'b0;
    mul_sat_nxt = mul_sat_r;
    mul_start_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          if (op == OP_MUL) begin
            mul_start_s = 1'b1;
            mul_sat_nxt = sat_en;
            state_nxt   = MUL;
          end else if (is_reserved(op)) begin
            done_nxt = 1'b1;
          end else begin
            result_nxt = alu_res_s;
            zero_nxt   = (alu_res_s == ALL_ZERO);
            carry_nxt  = alu_carry_s;
            ovf_nxt    = alu_ovf_s;
            done_nxt   = 1'b1;
          end
        end else begin
          state_nxt = IDLE;
        end
      end
      MUL: begin
        if (mul_done_s) begin
          result_nxt = mul_res_s;
          zero_nxt   = (mul_res_s == ALL_ZERO);
          carry_nxt  = mul_hi_nz_s;
          ovf_nxt    = mul_hi_nz_s;
          done_nxt   = 1'b1;
          state_nxt  = IDLE;
        end else if (!mul_busy_s) begin
          // Multiplier idle while we wait on it: recover without committing.
          state_nxt = IDLE;
        end else begin
          state_nxt = MUL;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, accumulator and status registers.
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      state_r   <= IDLE;
      result_r  <= ALL_ZERO;
      zero_r    <= 1'b0;
      carry_r   <= 1'b0;
      ovf_r     <= 1'b0;
      done_r    <= 1'b0;
      mul_sat_r <= 1'b0;
    end else begin
      state_r   <= state_nxt;
      result_r  <= result_nxt;
      zero_r    <= zero_nxt;
      carry_r   <= carry_nxt;
      ovf_r     <= ovf_nxt;
      done_r    <= done_nxt;
      mul_sat_r <= mul_sat_nxt;
    end
  end

  assign result     = result_r;
  assign flag_zero  = zero_r;
  assign flag_carry = carry_r;
  assign flag_ovf   = ovf_r;
  assign done       = done_r;

endmodule
